keypad_scanner_param: RTL
=========================

Name: keypad_scanner_param

Overview:
- Parametrised matrix-keypad scanner and the successor to the fixed 4x4 keypad front end. Supports ROWS x COLS matrices.
- Drives one-hot column strobes, synchronises the row returns and scans whole frames.
- Debounces presses and releases over multiple frames, detects multi-key presses, and emits a linear key code with a one-cycle valid pulse.
- Sits between the keypad pins and the calculator input controller.

Parameters:
ROWS, 4, number of keypad rows (>=2)
COLS, 4, number of keypad columns (>=2)
SCAN_DIV, 1000, clock cycles each column is driven per frame (>=4)
DEBOUNCE, 4, consecutive identical frames required to accept a press or a release (>=1)
KW, clog2(ROWS*COLS), key code width (derived, localparam)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable; low forces IDLE
rows_in  in  ROWS  raw row returns, active-high, asynchronous
cols_out  out  COLS  one-hot column drive, active-high
key_code  out  KW  row_index*COLS + col_index of the accepted key
key_valid  out  1  one-cycle pulse when a new debounced press is accepted
key_held  out  1  high from acceptance until a debounced release
multi_err  out  1  one-cycle pulse at end of any frame with >1 key detected

Behaviour:
- Reset (synchronous, active-high, `reset`):
  - All outputs go to 0; FSM goes to IDLE.
  - Column index, dwell counter, debounce counter and synchroniser flops all clear.
  - Reset wins over every other input, including mid-frame.
- Input synchronisation: rows_in passes through a 2-flop synchroniser before use.
- Scan timing:
  - Dwell counter runs 0..SCAN_DIV-1 per column, and cols_out holds bit c for the whole dwell.
  - The synchronised rows are sampled when the dwell counter equals SCAN_DIV-1.
  - The column index wraps COLS-1 -> 0. Frame = COLS*SCAN_DIV cycles.
- Frame accumulation:
  - Per frame, keep the count of asserted (row,col) hits, saturating at 2, plus the code of the last hit.
  - Evaluate on the sample cycle of column COLS-1. The outcome is exactly one of NONE (0 hits), SINGLE(code) (1 hit) or MULTI (>=2 hits). The accumulator then clears.
- FSM states: IDLE, RELEASED, PRESS_DB, PRESSED, RELEASE_DB.
  - IDLE: cols_out=0, counters held at 0, key_held=0. When enable=1, go to RELEASED on the next cycle and start at column 0.
  - RELEASED, on frame result:
    - SINGLE(k): latch candidate=k, set db_cnt=1.
      - If DEBOUNCE=1, accept immediately: key_code<=k, key_valid=1 next cycle, go to PRESSED.
      - Otherwise go to PRESS_DB.
    - NONE: no change.
  - PRESS_DB, on frame result:
    - SINGLE(candidate): db_cnt++. When db_cnt reaches DEBOUNCE, accept: key_code<=candidate, key_valid pulses 1 cycle, key_held<=1, go to PRESSED.
    - SINGLE(other): re-latch the candidate, db_cnt=1.
    - NONE: go to RELEASED.
  - PRESSED: any frame result other than NONE keeps the state (no new key_valid, key_code stable). NONE sets db_cnt=1 and goes to RELEASE_DB; if DEBOUNCE=1, go straight to RELEASED with key_held<=0.
  - RELEASE_DB: NONE increments db_cnt; at DEBOUNCE, key_held<=0 and go to RELEASED. Any hit returns to PRESSED.
- Multi-key handling:
  - A MULTI result pulses multi_err for 1 cycle (the cycle after evaluation) in every non-IDLE state.
  - In RELEASED and PRESS_DB, MULTI also goes to RELEASED with db_cnt=0.
  - In PRESSED, MULTI is treated as a hit.
- Latency: a stable press present from frame start gives key_valid 1 cycle after the evaluation of the DEBOUNCE-th frame. A release is debounced symmetrically.
- enable deassert at any point: on the next cycle go to IDLE, cols_out=0, key_held=0, no key_valid. A partial frame is discarded. On re-enable, scanning restarts at column 0, dwell 0.
- key_code holds its last accepted value until reset. key_valid and multi_err never assert in the same cycle.

Test Plan:
Common settings: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3; frame = 16 cycles.
1. Assert reset 2 cycles with enable=1 -> all outputs 0. After release, cols_out=0001 for 4 cycles, then 0010, 0100, 1000, 0001 (wrap).
2. Hold row 2 high whenever col 1 is driven -> after 3rd frame evaluation key_code=9, key_valid high exactly 1 cycle, key_held=1. No further key_valid over 10 more frames.
3. Bounce: key r1c3 present 2 frames, absent 1, present 2, absent -> key_valid never asserts, key_held stays 0.
4. Keys r0c0 and r3c3 together for 5 frames -> multi_err pulses once per frame (5 pulses), key_valid stays 0. Then release r3c3 -> key_code=0 accepted after 3 single frames.
5. After test 2, release key -> key_held drops after 3rd empty frame. Then press r3c0 -> key_valid with key_code=12.
6. Mid-scan events: drop enable mid-frame while key_held=1 -> next cycle cols_out=0, key_held=0. Re-enable -> cols_out=0001. Assert reset mid-PRESS_DB -> all outputs 0 next cycle and no key_valid.

Source files
------------

// File: rtl/keypad_scanner_param_if.sv
`default_nettype none
// =============================================================================
// Module  : keypad_scanner_param_if
// Brief   : Keypad pin and key-event bundle between scanner and its consumer.
// Rev     : 1.0  initial release
// =============================================================================
interface keypad_scanner_param_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int KW = $clog2(ROWS * COLS);

  logic            enable;
  logic [ROWS-1:0] rows_in;
  logic [COLS-1:0] cols_out;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;
  logic            multi_err;

  modport master (
    input  enable, rows_in,
    output cols_out, key_code, key_valid, key_held, multi_err
  );

  modport slave (
    output enable, rows_in,
    input  cols_out, key_code, key_valid, key_held, multi_err
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner_param.sv
`default_nettype none
// =============================================================================
// Module  : keypad_scanner_param
// Brief   : ROWS x COLS keypad scanner with frame debounce and multi-key detect.
// Rev     : 1.0  initial release
// =============================================================================
module keypad_scanner_param #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  keypad_scanner_param_if.master kp
);
  localparam int KW  = $clog2(ROWS * COLS);
  localparam int CW  = $clog2(COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE + 1);

  localparam logic [DW-1:0]   c_dwell_last = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   c_col_last   = CW'(COLS - 1);
  localparam logic [DBW-1:0]  c_db_max     = DBW'(DEBOUNCE);
  localparam logic [DBW-1:0]  c_db_one     = DBW'(1);
  localparam logic [COLS-1:0] c_col_one    = COLS'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RELEASED   = 3'd1,
    S_PRESS_DB   = 3'd2,
    S_PRESSED    = 3'd3,
    S_RELEASE_DB = 3'd4
  } state_t;

  state_t          r_state, w_state_next;
  logic [ROWS-1:0] r_rows_meta, r_rows_sync;
  logic [CW-1:0]   r_col;
  logic [DW-1:0]   r_dwell;
  logic [1:0]      r_acc_cnt;
  logic [KW-1:0]   r_acc_code;
  logic [DBW-1:0]  r_db_cnt, w_db_next, w_db_inc;
  logic [KW-1:0]   r_cand, w_cand_next;
  logic [KW-1:0]   r_key_code, w_code_next;
  logic            r_key_valid, w_valid_next;
  logic            r_key_held, w_held_next;
  logic            r_multi_err, w_multi_next;

  logic [1:0]      w_col_cnt, w_tot_cnt;
  logic [2:0]      w_sum;
  logic [KW-1:0]   w_tot_code;
  logic            w_sample, w_frame_done;
  logic            w_res_none, w_res_single, w_res_multi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rows_meta <= '0;
      r_rows_sync <= '0;
    end else begin
      r_rows_meta <= kp.rows_in;
      r_rows_sync <= r_rows_meta;
    end
  end

  assign w_sample     = (r_state != S_IDLE) && (r_dwell == c_dwell_last);
  assign w_frame_done = w_sample && (r_col == c_col_last);

  // Hits in the column being sampled, merged into the running frame tally.
  always_comb begin
    w_col_cnt  = 2'd0;
    w_tot_code = r_acc_code;
    for (int r = 0; r < ROWS; r++) begin
      if (r_rows_sync[r]) begin
        if (w_col_cnt != 2'd2) w_col_cnt = w_col_cnt + 2'd1;
        w_tot_code = KW'(r * COLS) + KW'(r_col);
      end
    end
  end

  assign w_sum     = {1'b0, r_acc_cnt} + {1'b0, w_col_cnt};
  assign w_tot_cnt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];

  assign w_res_none   = w_frame_done && (w_tot_cnt == 2'd0);
  assign w_res_single = w_frame_done && (w_tot_cnt == 2'd1);
  assign w_res_multi  = w_frame_done && (w_tot_cnt == 2'd2);

  // Scan position and frame tally; held at zero whenever not actively scanning.
  always_ff @(posedge clk) begin
    if (reset || !kp.enable || r_state == S_IDLE) begin
      r_col      <= '0;
      r_dwell    <= '0;
      r_acc_cnt  <= 2'd0;
      r_acc_code <= '0;
    end else if (w_sample) begin
      r_dwell <= '0;
      r_col   <= (r_col == c_col_last) ? '0 : r_col + CW'(1);
      if (w_frame_done) begin
        r_acc_cnt  <= 2'd0;
        r_acc_code <= '0;
      end else begin
        r_acc_cnt  <= w_tot_cnt;
        r_acc_code <= w_tot_code;
      end
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  assign w_db_inc = r_db_cnt + c_db_one;

  always_comb begin
    w_state_next = r_state;
    w_db_next    = r_db_cnt;
    w_cand_next  = r_cand;
    w_code_next  = r_key_code;
    w_valid_next = 1'b0;
    w_held_next  = r_key_held;
    w_multi_next = 1'b0;

    if (!kp.enable) begin
      w_state_next = S_IDLE;
      w_db_next    = '0;
      w_held_next  = 1'b0;
    end else begin
      w_multi_next = w_res_multi && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          w_state_next = S_RELEASED;
          w_db_next    = '0;
          w_held_next  = 1'b0;
        end
        S_RELEASED: begin
          if (w_res_single) begin
            w_cand_next = w_tot_code;
            w_db_next   = c_db_one;
            if (DEBOUNCE == 1) begin
              w_code_next  = w_tot_code;
              w_valid_next = 1'b1;
              w_held_next  = 1'b1;
              w_state_next = S_PRESSED;
            end else begin
              w_state_next = S_PRESS_DB;
            end
          end else if (w_res_multi) begin
            w_db_next = '0;
          end
        end
        S_PRESS_DB: begin
          if (w_res_single) begin
            if (w_tot_code == r_cand) begin
              w_db_next = w_db_inc;
              if (w_db_inc == c_db_max) begin
                w_code_next  = r_cand;
                w_valid_next = 1'b1;
                w_held_next  = 1'b1;
                w_state_next = S_PRESSED;
              end
            end else begin
              w_cand_next = w_tot_code;
              w_db_next   = c_db_one;
            end
          end else if (w_res_none || w_res_multi) begin
            w_db_next    = '0;
            w_state_next = S_RELEASED;
          end
        end
        S_PRESSED: begin
          if (w_res_none) begin
            w_db_next = c_db_one;
            if (DEBOUNCE == 1) begin
              w_held_next  = 1'b0;
              w_state_next = S_RELEASED;
            end else begin
              w_state_next = S_RELEASE_DB;
            end
          end
        end
        S_RELEASE_DB: begin
          if (w_res_none) begin
            w_db_next = w_db_inc;
            if (w_db_inc == c_db_max) begin
              w_held_next  = 1'b0;
              w_state_next = S_RELEASED;
            end
          end else if (w_res_single || w_res_multi) begin
            w_state_next = S_PRESSED;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_held_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_db_cnt    <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_db_cnt    <= w_db_next;
      r_cand      <= w_cand_next;
      r_key_code  <= w_code_next;
      r_key_valid <= w_valid_next;
      r_key_held  <= w_held_next;
      r_multi_err <= w_multi_next;
    end
  end

  assign kp.cols_out  = (r_state == S_IDLE) ? '0 : (c_col_one << r_col);
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;
  assign kp.multi_err = r_multi_err;
endmodule
`default_nettype wire
